// File: rtl/tap_window_pkg.sv
// Shared control-state encoding for the tap window buffer.
// Imported by the window control FSM and the tap register.
package tap_window_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } tw_state_t;

endpackage

// File: rtl/tap_shift_reg.sv
// Tap delay line: tap 0 newest in the low bits, shifts toward tap DEPTH-1.
// Shifts in either the input sample or zero; cleared by reset or clr.
module tap_shift_reg
  import tap_window_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic                   zero_sel,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] taps
);

  localparam int TW = DEPTH * WIDTH;

  logic [TW-1:0]    r_taps;
  logic [WIDTH-1:0] w_in;

  assign w_in = zero_sel ? '0 : din;
  assign taps = r_taps;

  // shift the window by one sample on each enabled cycle
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_taps <= '0;
    end else if (shift_en) begin
      r_taps <= {r_taps[TW-WIDTH-1:0], w_in};
    end
  end

endmodule

// File: rtl/tap_window_buffer.sv
// Sliding window of DEPTH samples with valid/ready handshake
// and zero tail padding on flush.
module tap_window_buffer
  import tap_window_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   din_zero,
  output logic                   din_ready,
  input  logic                   flush,
  output logic [DEPTH*WIDTH-1:0] dout,
  output logic                   win_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(DEPTH);

  tw_state_t r_state;
  tw_state_t w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nx;
  logic          r_win_valid;
  logic          w_win_nx;

  logic w_slot_free;
  logic w_accept;
  logic w_flush_shift;
  logic w_shift;
  logic w_zero;

  assign w_slot_free   = !r_win_valid || out_ready;
  assign din_ready     = !rstn ||
                         (w_slot_free && r_state != ST_FLUSH);
  assign w_accept      = rstn && din_valid && w_slot_free &&
                         r_state != ST_FLUSH;
  assign w_flush_shift = (r_state == ST_FLUSH) && w_slot_free &&
                         (r_fcnt != '0);
  assign w_shift       = w_accept || w_flush_shift;
  assign w_zero        = w_flush_shift || din_zero;

  assign win_valid = r_win_valid;
  assign busy      = (r_state == ST_FLUSH);

  tap_shift_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_taps (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .shift_en (w_shift),
    .zero_sel (w_zero),
    .din      (din),
    .taps     (dout)
  );

  // next state, fill/flush counters and window-valid flag
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fcnt_nx  = r_fcnt;
    w_win_nx   = r_win_valid && !out_ready;
    unique case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          if (r_cnt != CW'(DEPTH)) begin
            w_cnt_nx = r_cnt + 1'b1;
          end
          if (r_cnt == CW'(DEPTH - 1)) begin
            w_state_nx = ST_RUN;
            w_win_nx   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_win_nx = 1'b1;
        end
        if (flush) begin
          w_state_nx = ST_FLUSH;
          w_fcnt_nx  = FW'(DEPTH - 1);
        end
      end
      ST_FLUSH: begin
        if (w_flush_shift) begin
          w_win_nx  = 1'b1;
          w_fcnt_nx = r_fcnt - 1'b1;
        end else if (w_slot_free) begin
          w_state_nx = ST_FILL;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = ST_FILL;
        w_cnt_nx   = '0;
        w_fcnt_nx  = '0;
        w_win_nx   = 1'b0;
      end
    endcase
  end

  // control state register with reset and clear
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_fcnt      <= w_fcnt_nx;
      r_win_valid <= w_win_nx;
    end
  end

endmodule

// File: tb/tb_tap_window_buffer.sv
// Testbench for tap_window_buffer: vector table, directed corner
// sequences and randomized traffic against a sample-queue model.
module tb_tap_window_buffer;

  localparam int W  = 24;
  localparam int D  = 3;
  localparam int DW = W * D;

  logic          clk = 1'b0;
  logic          rstn, clr, din_valid, din_zero, din_ready;
  logic          flush, win_valid, out_ready, busy;
  logic [W-1:0]  din;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  tap_window_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .din_zero  (din_zero),
    .din_ready (din_ready),
    .flush     (flush),
    .dout      (dout),
    .win_valid (win_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: window contents, samples seen since fill start,
  // pending pad samples, flushing flag, unconsumed window flag
  logic [W-1:0] m_taps[D];
  int           m_cnt;
  int           m_pad;
  bit           m_flushing;
  bit           m_win;

  function automatic logic [DW-1:0] mk(logic [W-1:0] t0,
                                       logic [W-1:0] t1,
                                       logic [W-1:0] t2);
    return {t2, t1, t0};
  endfunction

  function automatic logic [DW-1:0] m_dout();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*W +: W] = m_taps[k];
    return r;
  endfunction

  function automatic logic m_ready();
    return !rstn || ((!m_win || out_ready) && !m_flushing);
  endfunction

  task automatic m_step();
    bit free, newwin, sh, was_full;
    logic [W-1:0] s;
    if (!rstn || clr) begin
      for (int k = 0; k < D; k++) m_taps[k] = '0;
      m_cnt = 0; m_pad = 0; m_flushing = 0; m_win = 0;
      return;
    end
    free = !m_win || out_ready;
    newwin = 0; sh = 0; s = '0;
    if (m_flushing) begin
      if (free) begin
        if (m_pad > 0) begin
          sh = 1; m_pad--; newwin = 1;
        end else begin
          m_flushing = 0; m_cnt = 0;
        end
      end
    end else begin
      was_full = (m_cnt == D);
      if (din_valid && free) begin
        sh = 1;
        s = din_zero ? '0 : din;
        if (m_cnt < D) m_cnt++;
        if (m_cnt == D) newwin = 1;
      end
      if (flush && was_full) begin
        m_flushing = 1; m_pad = D - 1;
      end
    end
    if (sh) begin
      for (int k = D - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
      m_taps[0] = s;
    end
    m_win = newwin ? 1'b1 : (free ? 1'b0 : m_win);
  endtask

  task automatic chk(string nm, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic dv, logic dz, logic [W-1:0] d,
                       logic fl, logic ordy);
    din_valid = dv; din_zero = dz; din = d;
    flush = fl; out_ready = ordy;
  endtask

  typedef struct {
    logic          dv;
    logic          dz;
    logic [W-1:0]  din;
    logic          fl;
    logic          er;
    logic          ew;
    logic          eb;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 24'h1, 1'b0, 1'b1, 1'b0, 1'b0,
                mk(24'h1, 24'h0, 24'h0)};
    tbl[1]  = '{1'b1, 1'b0, 24'h2, 1'b0, 1'b1, 1'b0, 1'b0,
                mk(24'h2, 24'h1, 24'h0)};
    tbl[2]  = '{1'b1, 1'b0, 24'h3, 1'b0, 1'b1, 1'b1, 1'b0,
                mk(24'h3, 24'h2, 24'h1)};
    tbl[3]  = '{1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b1,
                mk(24'h3, 24'h2, 24'h1)};
    tbl[4]  = '{1'b1, 1'b0, 24'hEE, 1'b0, 1'b0, 1'b1, 1'b1,
                mk(24'h0, 24'h3, 24'h2)};
    tbl[5]  = '{1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1,
                mk(24'h0, 24'h0, 24'h3)};
    tbl[6]  = '{1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                mk(24'h0, 24'h0, 24'h3)};
    tbl[7]  = '{1'b1, 1'b0, 24'hA, 1'b1, 1'b1, 1'b0, 1'b0,
                mk(24'hA, 24'h0, 24'h0)};
    tbl[8]  = '{1'b1, 1'b0, 24'hB, 1'b0, 1'b1, 1'b0, 1'b0,
                mk(24'hB, 24'hA, 24'h0)};
    tbl[9]  = '{1'b1, 1'b0, 24'hC, 1'b0, 1'b1, 1'b1, 1'b0,
                mk(24'hC, 24'hB, 24'hA)};
    tbl[10] = '{1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 1'b0,
                mk(24'h0, 24'hC, 24'hB)};

    rstn = 1'b0; clr = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_win", DW'(win_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_dout", dout, '0);
    chk("rst_ready", DW'(din_ready), DW'(1));
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].dv, tbl[i].dz, tbl[i].din, tbl[i].fl, 1'b1);
      #1;
      chk($sformatf("tbl%0d_ready", i), DW'(din_ready),
          DW'(tbl[i].er));
      tick();
      chk($sformatf("tbl%0d_win", i), DW'(win_valid),
          DW'(tbl[i].ew));
      chk($sformatf("tbl%0d_busy", i), DW'(busy), DW'(tbl[i].eb));
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
    end

    // backpressure holds window and input
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 24'h55, 1'b0, 1'b0);
      #1;
      chk("bp_ready", DW'(din_ready), '0);
      tick();
      chk("bp_win", DW'(win_valid), DW'(1));
      chk("bp_dout", dout, mk(24'h0, 24'hC, 24'hB));
    end
    drive(1'b1, 1'b0, 24'h55, 1'b0, 1'b1);
    #1;
    chk("bp_rel_ready", DW'(din_ready), DW'(1));
    tick();
    chk("bp_rel_dout", dout, mk(24'h55, 24'h0, 24'hC));
    chk("bp_rel_win", DW'(win_valid), DW'(1));

    // reset with a pending window, consumer stalled
    drive(1'b1, 1'b0, 24'h99, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rstwin_ready", DW'(din_ready), DW'(1));
    tick();
    chk("rstwin_win", DW'(win_valid), '0);
    chk("rstwin_dout", dout, '0);
    rstn = 1'b1;

    // two accepts, reset, then three fresh accepts needed
    drive(1'b1, 1'b0, 24'h11, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 24'h22, 1'b0, 1'b1); tick();
    rstn = 1'b0;
    drive(1'b1, 1'b0, 24'h77, 1'b0, 1'b1); tick();
    chk("rst2_dout", dout, '0);
    rstn = 1'b1;
    drive(1'b1, 1'b0, 24'h31, 1'b0, 1'b1); tick();
    chk("refill1_win", DW'(win_valid), '0);
    drive(1'b1, 1'b0, 24'h32, 1'b0, 1'b1); tick();
    chk("refill2_win", DW'(win_valid), '0);
    drive(1'b1, 1'b0, 24'h33, 1'b0, 1'b1); tick();
    chk("refill3_win", DW'(win_valid), DW'(1));
    chk("refill3_dout", dout, mk(24'h33, 24'h32, 24'h31));

    // clear in the middle of a flush
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1); tick();
    chk("fl_busy", DW'(busy), DW'(1));
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0); tick();
    chk("fl_win", DW'(win_valid), DW'(1));
    chk("fl_dout", dout, mk(24'h0, 24'h33, 24'h32));
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_win", DW'(win_valid), '0);
    chk("clr_busy", DW'(busy), '0);
    chk("clr_dout", dout, '0);
    #1;
    chk("clr_ready", DW'(din_ready), DW'(1));

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rstn = ($urandom_range(0, 99) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0),
            W'($urandom),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) != 0));
      #1;
      chk("rnd_ready", DW'(din_ready), DW'(m_ready()));
      tick();
      chk("rnd_win", DW'(win_valid), DW'(m_win));
      chk("rnd_busy", DW'(busy), DW'(m_flushing));
      chk("rnd_dout", dout, m_dout());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_window_buffer.md
TAP_WINDOW_BUFFER -- requirements
Module: tap_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning sample width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, meaning number of taps in the window (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of taps, fill count, window and state.
REQ-006 SHALL have port din  input  WIDTH  input sample.
REQ-007 SHALL have port din_valid  input  1  din is offered this cycle.
REQ-008 SHALL have port din_zero  input  1  on accept, store zero instead of din.
REQ-009 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-010 SHALL have port flush  input  1  request tail padding of DEPTH-1 zero samples.
REQ-011 SHALL have port dout  output  DEPTH*WIDTH  window; tap k at [k*WIDTH +: WIDTH], tap 0 newest, tap DEPTH-1 oldest.
REQ-012 SHALL have port win_valid  output  1  dout holds an unconsumed window.
REQ-013 SHALL have port out_ready  input  1  consumer takes window when win_valid high.
REQ-014 SHALL have port busy  output  1  high while in FLUSH state.

Function
REQ-015 States SHALL be FILL (fill count < DEPTH), RUN, FLUSH.
REQ-016 slot_free SHALL be (!win_valid || out_ready); din_ready SHALL be slot_free && state != FLUSH.
REQ-017 Accept SHALL be din_valid && din_ready; on accept taps shift by one (tap k <- tap k-1, tap 0 <- din_zero ? 0 : din).
REQ-018 Taps SHALL change only on accept or flush shift; dout SHALL be the tap registers directly, stable while win_valid is high and out_ready low.
REQ-019 FILL: each accept increments fill count; the accept bringing count to DEPTH SHALL move to RUN and set win_valid next cycle.
REQ-020 RUN: each accept SHALL set win_valid next cycle (latency 1 cycle from accept to window containing the sample).
REQ-021 win_valid SHALL clear after a cycle with out_ready high and no new window produced that cycle; a same-cycle new window keeps it high.
REQ-022 RUN with flush=1 SHALL enter FLUSH next cycle, loading flush counter with DEPTH-1; a sample accepted in the same cycle is included in the window.
REQ-023 flush SHALL be ignored in FILL and FLUSH.
REQ-024 FLUSH: each cycle with slot_free SHALL shift a zero into tap 0, produce a window and decrement the flush counter.
REQ-025 FLUSH SHALL exit to FILL with fill count 0 when the last padded window is consumed (win_valid low, counter 0); taps retain values.
REQ-026 clr SHALL override all other inputs except rstn: taps 0, fill count 0, flush counter 0, win_valid 0, state FILL, effective next cycle.
REQ-027 Fill count width SHALL be $clog2(DEPTH+1) bits and SHALL saturate at DEPTH.

Reset
REQ-028 On rstn low at a clk edge: taps 0, dout 0, win_valid 0, busy 0, fill count 0, flush counter 0, state FILL.
REQ-029 During reset din_ready SHALL be combinationally 1 (slot free, state FILL); accepts in reset cycles SHALL be discarded.
REQ-030 Reset mid-FLUSH or mid-window SHALL discard the pending window without handshake.

Structure
REQ-031 State encoding (FILL, RUN, FLUSH) SHALL live in shared package tap_window_pkg.
REQ-032 One sub-module, tap_shift_reg (WIDTH, DEPTH, shift enable, zero select, clear), SHALL hold the taps; control FSM SHALL stay in the top.

Verification
REQ-033 DEPTH=3, out_ready=1, accept 0x000001,0x000002,0x000003 back-to-back -> win_valid first high cycle after 3rd accept, dout taps {0x3,0x2,0x1}.
REQ-034 RUN, din_zero=1 with din=0xABCDEF -> tap 0 = 0, taps 1,2 shifted old values.
REQ-035 RUN, out_ready=0 for 4 cycles with din_valid=1 -> din_ready 0, dout unchanged, no sample lost; release -> next sample accepted same cycle.
REQ-036 RUN window {0x3,0x2,0x1}, flush=1 -> busy high, two padded windows {0,0x3,0x2},{0,0,0x3}, then FILL, din_ready 1, win_valid 0.
REQ-037 clr asserted mid-FLUSH with win_valid high -> next cycle win_valid 0, busy 0, dout 0, state FILL.
REQ-038 rstn low for one cycle after 2 accepts in FILL -> 3 new accepts required before first win_valid.
